branch_recovery_ctrl: RTL and testbench
=======================================

// Module: branch_recovery_ctrl
// PURPOSE
// - Commit-side sequencer for the branch queue (BQ).
// - Pops the BQ entry for each committing branch, then reads its missprediction flag.
// - On a missprediction it runs the recovery sequence: a squash pulse, a frontend
//   redirect with handshake, then a drain window. Commit is stalled until recovery ends.
// - Sits between ROB commit, the BQ pop port, the squash bus and the frontend redirect.
// PARAMETERS
// - XLEN          64  width of PCs
// - ID_W          6   width of ROB/sequence id carried on the squash bus
// - DRAIN_CYCLES  2   cycles held in DRAIN after the redirect is accepted (0 allowed)
// PORTS
// - clk              in   1      clock
// - rstn             in   1      reset, synchronous, active-low
// - commit_br_i      in   1      ROB head is a branch committing this cycle
// - commit_id_i      in   ID_W   ROB id of that branch
// - bq_empty_i       in   1      BQ holds no entries
// - bq_missp_i       in   1      missprediction flag of the BQ commit entry (bypassed, same cycle)
// - bq_pcnext_i      in   XLEN   resolved next PC of the BQ commit entry
// - bq_pop_o         out  1      pop the BQ commit entry
// - squash_valid_o   out  1      one-cycle squash pulse to the BQ, ROB and issue logic
// - squash_id_o      out  ID_W   id of the mispredicted branch
// - redirect_valid_o out  1      frontend redirect request
// - redirect_pc_o    out  XLEN   redirect target
// - redirect_ready_i in   1      frontend accepts the redirect
// - commit_stall_o   out  1      block further ROB commits
// BEHAVIOUR
// - FSM states: IDLE, SQUASH, REDIRECT, DRAIN. State, regs and counter are registered.
// - Outputs are combinational from state and inputs.
// - Reset: IDLE, drain counter 0, latched pc/id 0. All outputs 0 while rstn=0.
// - Reset takes effect from any state, mid-sequence included; no partial pulse survives.
// - IDLE:
//   - commit_stall_o=0.
//   - If commit_br_i && !bq_empty_i: bq_pop_o=1 in the same cycle (zero latency).
//   - If bq_missp_i=1 on that cycle: latch bq_pcnext_i and commit_id_i; next state is SQUASH.
//   - Otherwise stay in IDLE. Back-to-back correct branches pop every cycle.
// - commit_br_i with bq_empty_i=1: no pop, no state change, simulation $error.
// - SQUASH:
//   - squash_valid_o=1 and squash_id_o=latched id, exactly one cycle.
//   - Next state is REDIRECT.
// - REDIRECT:
//   - redirect_valid_o=1 and redirect_pc_o=latched pc.
//   - Held stable until redirect_ready_i=1.
//   - On accept: go to DRAIN with counter=DRAIN_CYCLES-1; go to IDLE if DRAIN_CYCLES==0.
// - DRAIN:
//   - Counter decrements each cycle; at 0 the next state is IDLE.
//   - Stays in DRAIN exactly DRAIN_CYCLES cycles.
// - commit_stall_o=1 in SQUASH, REDIRECT and DRAIN.
// - commit_br_i outside IDLE: ignored (no pop), simulation $error.
// - Timing, mispredicted commit at cycle T:
//   - squash pulse at T+1.
//   - redirect_valid from T+2.
//   - With ready at T+2 and DRAIN_CYCLES=2: IDLE at T+5; commit is accepted again at T+5.
// - squash_id_o and redirect_pc_o read 0 when their valid is low.
// CONFIGURATION
// - BRANCH_RECOVERY_STATS_EN defined:
//   - Adds outputs stat_br_o[31:0] (committed branches popped) and stat_missp_o[31:0]
//     (mispredictions).
//   - Both increment on the pop cycle and saturate at 32'hFFFF_FFFF.
//   - Cleared only by reset, never by squash.
// - Macro undefined: ports and counters are absent; all other behaviour is identical.
// TESTING
// - Reset during REDIRECT (rstn=0 one cycle) -> next cycle IDLE, all outputs 0,
//   and the next missp commit restarts the sequence at SQUASH.
// - Three correct branches T..T+2 (missp=0) -> bq_pop_o=1 on T,T+1,T+2;
//   squash and redirect never asserted; stall=0.
// - Missp commit at T, id=5, pcnext=0x8000_0040, ready=1 -> pop@T, squash(id 5)@T+1,
//   redirect 0x8000_0040@T+2, stall T+1..T+4, IDLE@T+5.
// - Same with ready low until T+6 -> redirect_valid and pc stable T+2..T+6, IDLE@T+9.
// - Missp with DRAIN_CYCLES=0 and ready at T+2 -> IDLE@T+3; commit_br_i at T+1 causes no pop.
// - commit_br_i with bq_empty_i=1 -> no pop, no $error suppression;
//   with STATS_EN, stat_br_o unchanged, and after 2 pops (1 missp) stat_br_o=2, stat_missp_o=1.

Source files
------------

// File: rtl/branch_recovery_ctrl.sv
// rtl/branch_recovery_ctrl.sv - commit-side branch queue pop and mispredict recovery sequencer
// Optional commit/mispredict counters are built when BRANCH_RECOVERY_STATS_EN is defined.
module branch_recovery_ctrl #(
  parameter int XLEN         = 64,
  parameter int ID_W         = 6,
  parameter int DRAIN_CYCLES = 2,
  parameter bit ASSERT_EN    = 1'b1
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            commit_br_i,
  input  logic [ID_W-1:0] commit_id_i,
  input  logic            bq_empty_i,
  input  logic            bq_missp_i,
  input  logic [XLEN-1:0] bq_pcnext_i,
  output logic            bq_pop_o,
  output logic            squash_valid_o,
  output logic [ID_W-1:0] squash_id_o,
  output logic            redirect_valid_o,
  output logic [XLEN-1:0] redirect_pc_o,
  input  logic            redirect_ready_i,
  output logic            commit_stall_o
`ifdef BRANCH_RECOVERY_STATS_EN
  ,
  output logic [31:0]     stat_br_o,
  output logic [31:0]     stat_missp_o
`endif
);

  localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SQUASH   = 2'd1,
    REDIRECT = 2'd2,
    DRAIN    = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      pc_q    <= '0;
      id_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs are gated by rstn so nothing leaks out during the reset cycle.
  always_comb begin
    state_d          = state_q;
    pc_d             = pc_q;
    id_d             = id_q;
    cnt_d            = cnt_q;
    bq_pop_o         = 1'b0;
    squash_valid_o   = 1'b0;
    squash_id_o      = '0;
    redirect_valid_o = 1'b0;
    redirect_pc_o    = '0;
    commit_stall_o   = 1'b0;
    if (rstn) begin
      case (state_q)
        IDLE: begin
          if (commit_br_i && !bq_empty_i) begin
            bq_pop_o = 1'b1;
            if (bq_missp_i) begin
              pc_d    = bq_pcnext_i;
              id_d    = commit_id_i;
              state_d = SQUASH;
            end
          end
        end
        SQUASH: begin
          squash_valid_o = 1'b1;
          squash_id_o    = id_q;
          commit_stall_o = 1'b1;
          state_d        = REDIRECT;
        end
        REDIRECT: begin
          redirect_valid_o = 1'b1;
          redirect_pc_o    = pc_q;
          commit_stall_o   = 1'b1;
          if (redirect_ready_i) begin
            if (DRAIN_CYCLES == 0) begin
              state_d = IDLE;
            end else begin
              state_d = DRAIN;
              cnt_d   = CNT_LOAD;
            end
          end
        end
        DRAIN: begin
          commit_stall_o = 1'b1;
          if (cnt_q == '0) begin
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

`ifdef BRANCH_RECOVERY_STATS_EN
  logic [31:0] stat_br_q, stat_br_d;
  logic [31:0] stat_missp_q, stat_missp_d;

  always_comb begin
    stat_br_d    = stat_br_q;
    stat_missp_d = stat_missp_q;
    if (bq_pop_o && (stat_br_q != 32'hFFFF_FFFF)) begin
      stat_br_d = stat_br_q + 32'd1;
    end
    if (bq_pop_o && bq_missp_i && (stat_missp_q != 32'hFFFF_FFFF)) begin
      stat_missp_d = stat_missp_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      stat_br_q    <= '0;
      stat_missp_q <= '0;
    end else begin
      stat_br_q    <= stat_br_d;
      stat_missp_q <= stat_missp_d;
    end
  end

  assign stat_br_o    = stat_br_q;
  assign stat_missp_o = stat_missp_q;
`endif

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (ASSERT_EN && rstn && commit_br_i) begin
      if (state_q != IDLE) begin
        $error("branch_recovery_ctrl: commit_br_i during recovery, ignored");
      end else if (bq_empty_i) begin
        $error("branch_recovery_ctrl: commit_br_i with empty branch queue");
      end
    end
  end
`endif

endmodule

// File: tb/tb_branch_recovery_ctrl.sv
// tb/tb_branch_recovery_ctrl.sv - scoreboard bench for branch_recovery_ctrl
// Two instances share stimulus: drain of 2 cycles and drain of 0 cycles.
module tb_branch_recovery_ctrl;

  typedef struct packed {
    logic        pop;
    logic        sqv;
    logic [5:0]  sqid;
    logic        rdv;
    logic [63:0] rdpc;
    logic        stall;
  } vec_t;

  logic        clk = 1'b0;
  logic        rstn;
  logic        commit_br;
  logic [5:0]  commit_id;
  logic        bq_empty;
  logic        bq_missp;
  logic [63:0] bq_pcnext;
  logic        redirect_ready;

  logic        bq_pop, squash_valid, redirect_valid, commit_stall;
  logic [5:0]  squash_id;
  logic [63:0] redirect_pc;
  logic        z_bq_pop, z_squash_valid, z_redirect_valid, z_commit_stall;
  logic [5:0]  z_squash_id;
  logic [63:0] z_redirect_pc;
`ifdef BRANCH_RECOVERY_STATS_EN
  logic [31:0] stat_br, stat_missp, z_stat_br, z_stat_missp;
`endif

  vec_t obs_w, z_obs_w;
  assign obs_w   = {bq_pop, squash_valid, squash_id, redirect_valid, redirect_pc, commit_stall};
  assign z_obs_w = {z_bq_pop, z_squash_valid, z_squash_id, z_redirect_valid, z_redirect_pc, z_commit_stall};

  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t exp_q[$];
  vec_t e;

  always #5 clk = ~clk;

  branch_recovery_ctrl #(.XLEN(64), .ID_W(6), .DRAIN_CYCLES(2), .ASSERT_EN(1'b0)) dut (
    .clk(clk), .rstn(rstn), .commit_br_i(commit_br), .commit_id_i(commit_id),
    .bq_empty_i(bq_empty), .bq_missp_i(bq_missp), .bq_pcnext_i(bq_pcnext),
    .bq_pop_o(bq_pop), .squash_valid_o(squash_valid), .squash_id_o(squash_id),
    .redirect_valid_o(redirect_valid), .redirect_pc_o(redirect_pc),
    .redirect_ready_i(redirect_ready), .commit_stall_o(commit_stall)
`ifdef BRANCH_RECOVERY_STATS_EN
    , .stat_br_o(stat_br), .stat_missp_o(stat_missp)
`endif
  );

  branch_recovery_ctrl #(.XLEN(64), .ID_W(6), .DRAIN_CYCLES(0), .ASSERT_EN(1'b0)) dut0 (
    .clk(clk), .rstn(rstn), .commit_br_i(commit_br), .commit_id_i(commit_id),
    .bq_empty_i(bq_empty), .bq_missp_i(bq_missp), .bq_pcnext_i(bq_pcnext),
    .bq_pop_o(z_bq_pop), .squash_valid_o(z_squash_valid), .squash_id_o(z_squash_id),
    .redirect_valid_o(z_redirect_valid), .redirect_pc_o(z_redirect_pc),
    .redirect_ready_i(redirect_ready), .commit_stall_o(z_commit_stall)
`ifdef BRANCH_RECOVERY_STATS_EN
    , .stat_br_o(z_stat_br), .stat_missp_o(z_stat_missp)
`endif
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic cb, input logic [5:0] id, input logic empty,
                       input logic missp, input logic [63:0] pc, input logic rdy);
    commit_br      = cb;
    commit_id      = id;
    bq_empty       = empty;
    bq_missp       = missp;
    bq_pcnext      = pc;
    redirect_ready = rdy;
  endtask

  function automatic vec_t mk(input logic pop, input logic sqv, input logic [5:0] sqid,
                              input logic rdv, input logic [63:0] rdpc, input logic stall);
    mk = {pop, sqv, sqid, rdv, rdpc, stall};
  endfunction

  task automatic test_reset();
    rstn = 1'b0;
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      if (c == 2) rstn = 1'b1;
      drive(c < 2, 6'd9, 1'b0, c < 2, 64'hDEAD_BEEF, 1'b1);
      exp_q.push_back(mk(0, 0, 0, 0, 0, 0));
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if (obs_w !== e) begin
        n_fail++;
        $display("FAIL reset c%0d: got %h want %h", c, obs_w, e);
      end
      n_checks++;
      if (z_obs_w !== e) begin
        n_fail++;
        $display("FAIL reset_d0 c%0d: got %h want %h", c, z_obs_w, e);
      end
    end
  endtask

  task automatic test_correct_b2b();
    for (int c = 0; c < 4; c++) begin
      next_cycle();
      drive(c < 3, 6'(c + 1), 1'b0, 1'b0, 64'h1000 + 64'(c), 1'b0);
      exp_q.push_back(mk(c < 3, 0, 0, 0, 0, 0));
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if (obs_w !== e) begin
        n_fail++;
        $display("FAIL b2b c%0d: got %h want %h", c, obs_w, e);
      end
    end
  endtask

  // Mispredict at c=0; frontend accepts at c=ready_at; drain of 2; commit again after.
  task automatic test_missp(input int ready_at, input logic [5:0] id, input logic [63:0] pc);
    for (int c = 0; c <= ready_at + 3; c++) begin
      next_cycle();
      if (c == 0)
        drive(1'b1, id, 1'b0, 1'b1, pc, 1'b0);
      else if (c == ready_at + 3)
        drive(1'b1, 6'd33, 1'b0, 1'b0, 64'h0, 1'b0);
      else
        drive(1'b0, 6'($urandom), 1'b0, 1'($urandom), {$urandom, $urandom}, c == ready_at);
      exp_q.push_back(mk(c == 0 || c == ready_at + 3, c == 1, (c == 1) ? id : 6'd0,
                         c >= 2 && c <= ready_at, (c >= 2 && c <= ready_at) ? pc : 64'd0,
                         c >= 1 && c <= ready_at + 2));
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if (obs_w !== e) begin
        n_fail++;
        $display("FAIL missp_r%0d c%0d: got %h want %h", ready_at, c, obs_w, e);
      end
    end
  endtask

  task automatic test_drain0();
    for (int c = 0; c < 4; c++) begin
      next_cycle();
      drive(c <= 1, 6'd17, 1'b0, c <= 1, 64'h4444_0000, c == 2);
      exp_q.push_back(mk(c == 0, c == 1, (c == 1) ? 6'd17 : 6'd0, c == 2,
                         (c == 2) ? 64'h4444_0000 : 64'd0, c == 1 || c == 2));
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if (z_obs_w !== e) begin
        n_fail++;
        $display("FAIL drain0 c%0d: got %h want %h", c, z_obs_w, e);
      end
    end
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      drive(1'b0, 6'd0, 1'b0, 1'b0, 64'd0, 1'b0);
    end
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 11; c++) begin
      next_cycle();
      rstn = (c != 3);
      if (c == 0)      drive(1'b1, 6'd12, 1'b0, 1'b1, 64'hAAAA_0000, 1'b0);
      else if (c == 5) drive(1'b1, 6'd21, 1'b0, 1'b1, 64'hBBBB_0010, 1'b0);
      else             drive(1'b0, 6'd0, 1'b0, 1'b0, 64'd0, c == 7);
      case (c)
        0, 5:    exp_q.push_back(mk(1, 0, 0, 0, 0, 0));
        1:       exp_q.push_back(mk(0, 1, 6'd12, 0, 0, 1));
        2:       exp_q.push_back(mk(0, 0, 0, 1, 64'hAAAA_0000, 1));
        6:       exp_q.push_back(mk(0, 1, 6'd21, 0, 0, 1));
        7:       exp_q.push_back(mk(0, 0, 0, 1, 64'hBBBB_0010, 1));
        8, 9:    exp_q.push_back(mk(0, 0, 0, 0, 0, 1));
        default: exp_q.push_back(mk(0, 0, 0, 0, 0, 0));
      endcase
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if (obs_w !== e) begin
        n_fail++;
        $display("FAIL reset_mid c%0d: got %h want %h", c, obs_w, e);
      end
    end
  endtask

  task automatic test_bq_empty();
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      drive(c < 2, 6'd3, 1'b1, c == 1, 64'h77, 1'b0);
      exp_q.push_back(mk(0, 0, 0, 0, 0, 0));
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if (obs_w !== e) begin
        n_fail++;
        $display("FAIL bq_empty c%0d: got %h want %h", c, obs_w, e);
      end
    end
  endtask

`ifdef BRANCH_RECOVERY_STATS_EN
  task automatic test_stats();
    next_cycle();
    rstn = 1'b0;
    drive(1'b0, 6'd0, 1'b0, 1'b0, 64'd0, 1'b0);
    next_cycle();
    rstn = 1'b1;
    @(negedge clk);
    n_checks++;
    if (stat_br !== 32'd0 || stat_missp !== 32'd0) begin
      n_fail++;
      $display("FAIL stats_reset: got %0d/%0d want 0/0", stat_br, stat_missp);
    end
    for (int c = 0; c < 8; c++) begin
      next_cycle();
      drive(c < 3, 6'd2, c == 0, c == 2, 64'h40, c == 4);
      if (c == 1) begin
        @(negedge clk);
        n_checks++;
        if (stat_br !== 32'd0) begin
          n_fail++;
          $display("FAIL stats_empty: got %0d want 0", stat_br);
        end
      end
    end
    @(negedge clk);
    n_checks++;
    if (stat_br !== 32'd2 || stat_missp !== 32'd1) begin
      n_fail++;
      $display("FAIL stats_count: got %0d/%0d want 2/1", stat_br, stat_missp);
    end
  endtask
`endif

  initial begin
    rstn = 1'b0;
    drive(1'b0, 6'd0, 1'b0, 1'b0, 64'd0, 1'b0);
    test_reset();
    test_correct_b2b();
    test_missp(2, 6'd5, 64'h8000_0040);
    test_missp(6, 6'd5, 64'h8000_0040);
    test_missp(3, 6'd63, 64'hFFFF_FFFF_FFFF_FFFC);
    test_drain0();
    test_reset_mid();
    test_bq_empty();
`ifdef BRANCH_RECOVERY_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
